throttle_sched: RTL and testbench
=================================

THROTTLE_SCHED -- requirements
Module: throttle_sched

Interface
REQ-001 Parameter NUM_LEVELS, default 6, number of speed levels (0..NUM_LEVELS-1), range 2..8, SHALL be supported.
REQ-002 Parameter DWELL_CYCLES, default 5_000_000, minimum CLK_50 cycles spent at each intermediate level during a ramp, SHALL be >=1.
REQ-003 Parameter SIM_DIV, default 1, divisor applied to every tick period (integer division), SHALL exist for simulation speed-up.
REQ-004 CLK_50  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 up_req  in  1  debounced manual speed-up level.
REQ-007 dn_req  in  1  debounced manual speed-down level.
REQ-008 tgt_valid  in  1  host target-level request valid.
REQ-009 tgt_level  in  3  host requested level.
REQ-010 tgt_ready  out  1  scheduler can accept a host target.
REQ-011 level  out  3  current applied speed level.
REQ-012 tick  out  1  one-cycle enable pulse at the rate of the current level.
REQ-013 busy  out  1  high while a ramp is in progress.

Function
REQ-014 Tick period SHALL be PERIOD[level]/SIM_DIV cycles, PERIOD = {50_000_000, 25_000_000, 16_666_666, 12_500_000, 10_000_000, 8_333_333} (1..6 Hz); tick high exactly on the last cycle of each period.
REQ-015 On any change of level the tick counter SHALL restart at 0 in the same cycle, so the first tick at the new level comes one full new period later.
REQ-016 FSM states IDLE, STEP, DWELL; tgt_ready = 1 only in IDLE; busy = 1 in STEP and DWELL.
REQ-017 IDLE: tgt_valid && tgt_ready accepts; target = min(tgt_level, NUM_LEVELS-1); if target == level stay IDLE, else go STEP next cycle.
REQ-018 STEP: level moves one toward target (1 cycle); if new level == target -> IDLE, else -> DWELL.
REQ-019 DWELL: count DWELL_CYCLES cycles, then -> STEP.
REQ-020 Manual: rising edge of up_req (dn_req) in IDLE SHALL change level by +1 (-1) next cycle, saturating at NUM_LEVELS-1 (0); no state change.
REQ-021 Simultaneous rising edges on up_req and dn_req SHALL be ignored.
REQ-022 Host acceptance and a manual edge in the same cycle: host wins, manual edge dropped.
REQ-023 Manual edges during STEP/DWELL SHALL be dropped (not queued); tgt_valid outside IDLE SHALL stay pending per valid/ready.
REQ-024 Edge detectors SHALL register up_req/dn_req; an input held high produces one action only.

Reset
REQ-025 During reset: level=0, tick=0, busy=0, tgt_ready=0, tick counter=0, dwell counter=0, state IDLE, edge registers=0.
REQ-026 First edge after deassertion: tgt_ready=1; reset mid-ramp SHALL abandon the target.

Configuration
REQ-027 Macro THROTTLE_SCHED_RAMP_EN defined: stepwise ramp per REQ-017..019.
REQ-028 Macro undefined: accepted target SHALL be applied in one STEP (level = target), then IDLE; DWELL unreachable, busy high one cycle.

Structure
REQ-029 Package throttle_pkg SHALL hold LEVEL_W (3), MAX_LEVELS (8), the PERIOD table/lookup function and the FSM state typedef.
REQ-030 Sub-module tick_gen (period in, restart in, tick out) SHALL implement the tick counter; FSM and arbitration stay in throttle_sched.

Verification (SIM_DIV=1_000_000 -> periods 50,25,16,12,10,8; DWELL_CYCLES=4)
REQ-031 Reset release, idle -> level=0, tick every 50 cycles, tgt_ready=1.
REQ-032 Five up_req pulses then a sixth -> level 1..5, stays 5; tick period 8; both buttons pressed same cycle -> level unchanged.
REQ-033 Host tgt_level=4 from 0, RAMP_EN -> level 1,2,3,4 with 5 cycles between steps, busy high throughout, tgt_ready low until level=4.
REQ-034 Host tgt_level=7 -> clamps, final level 5; host and up_req same cycle -> only host honoured.
REQ-035 reset asserted during DWELL at level 2 -> level 0 asynchronously, busy 0, no further steps after release.
REQ-036 RAMP_EN undefined, target 5 from 0 -> level 5 one cycle after STEP, busy one cycle; tick restarts with period 8.

Source files
------------

// File: rtl/throttle_pkg.sv
// Shared widths, FSM state type and the per-level tick period table for throttle_sched.
package throttle_pkg;

  localparam int LEVEL_W    = 3;
  localparam int MAX_LEVELS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    DWELL = 2'd2
  } state_t;

  // Undivided tick period in CLK_50 cycles; level n ticks at (n+1) Hz.
  function automatic logic [31:0] period_base(input logic [LEVEL_W-1:0] lvl);
    logic [31:0] p;
    case (lvl)
      3'd0:    p = 32'd50_000_000;
      3'd1:    p = 32'd25_000_000;
      3'd2:    p = 32'd16_666_666;
      3'd3:    p = 32'd12_500_000;
      3'd4:    p = 32'd10_000_000;
      3'd5:    p = 32'd8_333_333;
      3'd6:    p = 32'd7_142_857;
      3'd7:    p = 32'd6_250_000;
      default: p = 32'd50_000_000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/throttle_sched_tick_gen.sv
// Free-running tick counter: one-cycle pulse on the last cycle of each period,
// restarted from zero whenever the scheduler changes level.
module tick_gen
  import throttle_pkg::*;
(
  input  logic        CLK_50,
  input  logic        reset,
  input  logic [31:0] i_period,
  input  logic        i_restart,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic        r_tick;

  // Wrap on the cycle after a tick, or jump to zero on a level change.
  always_comb begin
    if (i_restart || r_tick) begin
      w_cnt_next = 32'd0;
    end else begin
      w_cnt_next = r_cnt + 32'd1;
    end
  end

  // i_period already reflects the level applied next cycle, so the pulse lines up with it.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_cnt  <= 32'd0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == (i_period - 32'd1));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/throttle_sched.sv
// Speed-level scheduler: host target ramps, manual up/down buttons and a per-level tick.
// Define THROTTLE_SCHED_RAMP_EN for stepwise ramps with dwell; otherwise a target applies in one step.
module throttle_sched
  import throttle_pkg::*;
#(
  parameter int NUM_LEVELS   = 6,
  parameter int DWELL_CYCLES = 5_000_000,
  parameter int SIM_DIV      = 1
) (
  input  logic               CLK_50,
  input  logic               reset,
  input  logic               up_req,
  input  logic               dn_req,
  input  logic               tgt_valid,
  input  logic [LEVEL_W-1:0] tgt_level,
  output logic               tgt_ready,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               busy
);

  localparam logic [LEVEL_W-1:0] TOP_LVL    = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] ONE_LVL    = LEVEL_W'(1'b1);
  localparam logic [LEVEL_W-1:0] ZERO_LVL   = {LEVEL_W{1'b0}};
  localparam logic [31:0]        DWELL_LAST = 32'(DWELL_CYCLES - 1);

  state_t             r_state, w_state_next;
  logic [LEVEL_W-1:0] r_level, w_level_next;
  logic [LEVEL_W-1:0] r_target, w_target_next;
  logic [LEVEL_W-1:0] w_clamped;
  logic [31:0]        r_dwell, w_dwell_next;
  logic               r_up_q, r_dn_q, r_ready, r_busy;
  logic               w_up_rise, w_dn_rise, w_accept, w_restart;
  logic [31:0]        w_period_tab [MAX_LEVELS];
  logic [31:0]        w_period;

  for (genvar g = 0; g < MAX_LEVELS; g++) begin : g_period
    localparam logic [31:0] PER = period_base(LEVEL_W'(g)) / 32'(SIM_DIV);
    assign w_period_tab[g] = (PER == 32'd0) ? 32'd1 : PER;
  end

  assign w_up_rise = up_req & ~r_up_q;
  assign w_dn_rise = dn_req & ~r_dn_q;
  assign w_accept  = tgt_valid & r_ready;
  assign w_clamped = (tgt_level > TOP_LVL) ? TOP_LVL : tgt_level;

`ifdef THROTTLE_SCHED_RAMP_EN
  logic [LEVEL_W-1:0] w_toward;
  assign w_toward = (r_target > r_level) ? (r_level + ONE_LVL) : (r_level - ONE_LVL);
`endif

  // Next-state, level and dwell logic; host acceptance outranks a manual edge.
  always_comb begin
    w_state_next  = r_state;
    w_level_next  = r_level;
    w_target_next = r_target;
    w_dwell_next  = r_dwell;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_target_next = w_clamped;
          if (w_clamped != r_level) begin
            w_state_next = STEP;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_up_rise && !w_dn_rise) begin
          if (r_level != TOP_LVL) begin
            w_level_next = r_level + ONE_LVL;
          end else begin
            w_level_next = r_level;
          end
        end else if (w_dn_rise && !w_up_rise) begin
          if (r_level != ZERO_LVL) begin
            w_level_next = r_level - ONE_LVL;
          end else begin
            w_level_next = r_level;
          end
        end else begin
          w_level_next = r_level;
        end
      end
      STEP: begin
`ifdef THROTTLE_SCHED_RAMP_EN
        w_level_next = w_toward;
        w_dwell_next = 32'd0;
        if (w_toward == r_target) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DWELL;
        end
`else
        w_level_next = r_target;
        w_state_next = IDLE;
`endif
      end
      DWELL: begin
        if (r_dwell == DWELL_LAST) begin
          w_state_next = STEP;
          w_dwell_next = 32'd0;
        end else begin
          w_dwell_next = r_dwell + 32'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_restart = (w_level_next != r_level);
  assign w_period  = w_period_tab[w_level_next];

  // Scheduler registers; reset drops any ramp in progress and its target.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_level  <= ZERO_LVL;
      r_target <= ZERO_LVL;
      r_dwell  <= 32'd0;
      r_up_q   <= 1'b0;
      r_dn_q   <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_level  <= w_level_next;
      r_target <= w_target_next;
      r_dwell  <= w_dwell_next;
      r_up_q   <= up_req;
      r_dn_q   <= dn_req;
      r_ready  <= (w_state_next == IDLE);
      r_busy   <= (w_state_next != IDLE);
    end
  end

  assign tgt_ready = r_ready;
  assign level     = r_level;
  assign busy      = r_busy;

  tick_gen u_tick_gen (
    .CLK_50    (CLK_50),
    .reset     (reset),
    .i_period  (w_period),
    .i_restart (w_restart),
    .o_tick    (tick)
  );

endmodule

// File: tb/tb_throttle_sched.sv
// Directed plus randomized bench for throttle_sched against an event-schedule reference model.
module tb_throttle_sched;

  localparam int NL = 6;
  localparam int DW = 4;
  localparam int SD = 1_000_000;

  logic       CLK_50    = 1'b0;
  logic       reset     = 1'b1;
  logic       up_req    = 1'b0;
  logic       dn_req    = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [2:0] tgt_level = 3'd0;
  logic       tgt_ready;
  logic [2:0] level;
  logic       tick;
  logic       busy;

  throttle_sched #(.NUM_LEVELS(NL), .DWELL_CYCLES(DW), .SIM_DIV(SD)) dut (
    .CLK_50    (CLK_50),
    .reset     (reset),
    .up_req    (up_req),
    .dn_req    (dn_req),
    .tgt_valid (tgt_valid),
    .tgt_level (tgt_level),
    .tgt_ready (tgt_ready),
    .level     (level),
    .tick      (tick),
    .busy      (busy)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    longint n;
    int     lvl;
  } ev_t;

  ev_t    m_sched[$];
  int     m_level;
  int     m_phase;
  bit     m_ready;
  bit     m_busy;
  bit     m_up_q;
  bit     m_dn_q;
  longint edge_n;
  int     n_vec;
  int     n_fail;

  function automatic int period_of(input int lvl);
    return (50_000_000 / (lvl + 1)) / SD;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_phase = 0;
    m_ready = 1'b0;
    m_busy  = 1'b0;
    m_up_q  = 1'b0;
    m_dn_q  = 1'b0;
    m_sched.delete();
  endtask

  // Accepted target turns into a list of (edge, level) events.
  task automatic schedule(input int t);
    ev_t e;
`ifdef THROTTLE_SCHED_RAMP_EN
    int d;
    int dir;
    d   = (t > m_level) ? (t - m_level) : (m_level - t);
    dir = (t > m_level) ? 1 : -1;
    for (int k = 1; k <= d; k++) begin
      e.n   = edge_n + 1 + longint'((DW + 1) * (k - 1));
      e.lvl = m_level + dir * k;
      m_sched.push_back(e);
    end
`else
    e.n   = edge_n + 1;
    e.lvl = t;
    m_sched.push_back(e);
`endif
  endtask

  task automatic step();
    int old;
    bit up_r;
    bit dn_r;
    int t;
    @(posedge CLK_50);
    #1;
    edge_n++;
    if (reset) begin
      model_reset();
    end else begin
      old  = m_level;
      up_r = up_req && !m_up_q;
      dn_r = dn_req && !m_dn_q;
      if (!m_busy && tgt_valid && m_ready) begin
        t = (int'(tgt_level) > NL - 1) ? NL - 1 : int'(tgt_level);
        if (t != m_level) schedule(t);
      end else if (!m_busy && (up_r != dn_r)) begin
        if (up_r && m_level < NL - 1) m_level++;
        if (dn_r && m_level > 0) m_level--;
      end
      while (m_sched.size() > 0 && m_sched[0].n == edge_n) begin
        m_level = m_sched[0].lvl;
        void'(m_sched.pop_front());
      end
      m_busy  = (m_sched.size() > 0);
      m_ready = !m_busy;
      m_up_q  = up_req;
      m_dn_q  = dn_req;
      if (m_level != old) m_phase = 0;
      else m_phase++;
    end
    check("level", level, m_level);
    check("tick", tick, ((m_phase % period_of(m_level)) == period_of(m_level) - 1) ? 1 : 0);
    check("busy", busy, m_busy);
    check("tgt_ready", tgt_ready, m_ready);
  endtask

  task automatic press(input logic up, input logic dn);
    up_req = up;
    dn_req = dn;
    repeat (2) step();
    up_req = 1'b0;
    dn_req = 1'b0;
    repeat (2) step();
  endtask

  // Holds valid until the scheduler is ready, then presents it for one accepting edge.
  task automatic host(input int t, input bit with_up);
    int i;
    i = 0;
    tgt_valid = 1'b1;
    tgt_level = 3'(t);
    while (!m_ready && i < 200) begin
      step();
      i++;
    end
    check("host_ready", tgt_ready, 1);
    if (with_up) up_req = 1'b1;
    step();
    tgt_valid = 1'b0;
    up_req    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_busy; i++) step();
    check("ramp_done", busy, 0);
  endtask

  initial begin
    bit acc;
    n_vec  = 0;
    n_fail = 0;
    edge_n = 0;
    model_reset();

    repeat (3) step();
    reset = 1'b0;
    repeat (120) step();

    repeat (6) press(1'b1, 1'b0);
    repeat (24) step();
    press(1'b1, 1'b1);
    dn_req = 1'b1;
    repeat (6) step();
    dn_req = 1'b0;
    repeat (3) step();
    press(1'b1, 1'b0);

    host(0, 1'b0);
    wait_idle();
    host(4, 1'b0);
    step();
    press(1'b1, 1'b0);
    wait_idle();
    host(7, 1'b1);
    wait_idle();
    repeat (20) step();

    host(4, 1'b0);
    host(1, 1'b0);
    wait_idle();
    host(0, 1'b0);
    wait_idle();

`ifdef THROTTLE_SCHED_RAMP_EN
    host(5, 1'b0);
    for (int i = 0; i < 100 && m_level != 2; i++) step();
    step();
`else
    host(2, 1'b0);
    step();
`endif
    reset = 1'b1;
    #2;
    check("async_level", level, 0);
    check("async_busy", busy, 0);
    check("async_ready", tgt_ready, 0);
    check("async_tick", tick, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (30) step();

    host(5, 1'b0);
    wait_idle();
    repeat (20) step();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) up_req = ~up_req;
      if ($urandom_range(0, 9) == 0) dn_req = ~dn_req;
      if (!tgt_valid && $urandom_range(0, 29) == 0) begin
        tgt_valid = 1'b1;
        tgt_level = 3'($urandom_range(0, 7));
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      acc = tgt_valid && m_ready;
      step();
      if (acc) tgt_valid = 1'b0;
    end
    reset  = 1'b0;
    up_req = 1'b0;
    dn_req = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
